// File: rtl/leaf_hub_link.sv
// leaf_hub_link: leaf endpoint stamping/buffering upstream words and filtering/buffering root traffic
module leaf_hub_link_fifo2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  logic [W-1:0] mem [2];
  logic         wp, rp;
  logic [1:0]   cnt;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wp     <= 1'b0;
      rp     <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (push) begin
        mem[wp] <= din;
        wp      <= ~wp;
      end
      if (pop) rp <= ~rp;
      cnt <= cnt + 2'(push) - 2'(pop);
    end
  assign dout  = mem[rp];
  assign full  = cnt == 2'd2;
  assign empty = cnt == 2'd0;
endmodule

module leaf_hub_link #(
  parameter logic [7:0] FPGA_ID  = 8'd1,
  parameter logic [7:0] BCAST_ID = 8'hFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [47:0] loc_tx_data,
  input  logic [7:0]  loc_tx_dest,
  input  logic        loc_tx_valid,
  output logic        loc_tx_ready,
  output logic [63:0] up_tx_data,
  output logic        up_tx_valid,
  input  logic        up_tx_ready,
  input  logic [63:0] up_rx_data,
  input  logic        up_rx_valid,
  output logic        up_rx_ready,
  output logic [47:0] loc_rx_data,
  output logic [7:0]  loc_rx_src,
  output logic        loc_rx_bcast,
  output logic        loc_rx_valid,
  input  logic        loc_rx_ready,
  output logic [15:0] tx_count,
  output logic [15:0] rx_count,
  output logic [15:0] drop_count
);
  logic tx_full, tx_empty, rx_full, rx_empty;
  logic tx_push, tx_pop, rx_fire, rx_push, rx_pop, hit, bc, drop;
  assign loc_tx_ready = !tx_full;
  assign up_tx_valid  = !tx_empty;
  assign up_rx_ready  = !rx_full;
  assign loc_rx_valid = !rx_empty;
  assign tx_push = loc_tx_valid && loc_tx_ready;
  assign tx_pop  = up_tx_valid && up_tx_ready;
  assign rx_pop  = loc_rx_valid && loc_rx_ready;
  assign rx_fire = up_rx_valid && up_rx_ready;
  assign hit     = up_rx_data[63:56] == FPGA_ID;
  assign bc      = up_rx_data[63:56] == BCAST_ID;
  assign rx_push = rx_fire && (hit || bc);
  assign drop    = rx_fire && !(hit || bc);
  leaf_hub_link_fifo2 #(.W(64)) u_tx (
    .clk(clk), .reset(reset), .push(tx_push), .pop(tx_pop),
    .din({loc_tx_dest, FPGA_ID, loc_tx_data}), .dout(up_tx_data),
    .full(tx_full), .empty(tx_empty)
  );
  leaf_hub_link_fifo2 #(.W(57)) u_rx (
    .clk(clk), .reset(reset), .push(rx_push), .pop(rx_pop),
    .din({bc, up_rx_data[55:0]}), .dout({loc_rx_bcast, loc_rx_src, loc_rx_data}),
    .full(rx_full), .empty(rx_empty)
  );
  // counters stick at all-ones rather than wrapping
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      tx_count   <= 16'd0;
      rx_count   <= 16'd0;
      drop_count <= 16'd0;
    end else begin
      if (tx_pop && ~&tx_count) tx_count <= tx_count + 16'd1;
      if (rx_pop && ~&rx_count) rx_count <= rx_count + 16'd1;
      if (drop && ~&drop_count) drop_count <= drop_count + 16'd1;
    end
endmodule

// File: doc/leaf_hub_link.md
# leaf_hub_link

Leaf-side endpoint of the inter-FPGA message network; one instance per non-root FPGA, at the opposite end of that FPGA's 64-bit channel to the root hub. On the transmit side it stamps each local 48-bit payload with a destination and its own FPGA ID, buffers it, and sends it upstream. On the receive side it buffers root traffic, accepts only words addressed to this FPGA or broadcast, discards the rest, and keeps saturating traffic counters.

## Interface
Parameters:
- FPGA_ID, 1: this FPGA's 8-bit ID (1..254); written into source field, matched against destination field
- BCAST_ID, 8'hFF: destination accepted by every leaf

Ports:
- clk  in  1  single clock
- reset  in  1  asynchronous, active-high
- loc_tx_data  in  48  payload from local stage controller
- loc_tx_dest  in  8  destination FPGA ID for loc_tx_data
- loc_tx_valid / loc_tx_ready  in / out  1  local-to-upstream handshake
- up_tx_data  out  64  word to root hub
- up_tx_valid / up_tx_ready  out / in  1
- up_rx_data  in  64  word from root hub
- up_rx_valid / up_rx_ready  in / out  1
- loc_rx_data  out  48  delivered payload
- loc_rx_src  out  8  source FPGA ID of delivered payload
- loc_rx_bcast  out  1  delivered word was broadcast
- loc_rx_valid / loc_rx_ready  out / in  1
- tx_count, rx_count, drop_count  out  16 each  saturating counters

## Operation
- Word format: [63:56] dest, [55:48] src, [47:0] payload.
- TX path: 2-entry FIFO. Transfer when loc_tx_valid && loc_tx_ready; stored word = {loc_tx_dest, FPGA_ID, loc_tx_data}. No destination check on TX: dest == FPGA_ID still goes upstream (root routes it back).
- RX path: on up_rx_valid && up_rx_ready, classify: dest == FPGA_ID -> accept; dest == BCAST_ID -> accept with bcast flag; else -> drop (consumed, not stored, drop_count++). Accepted words enter 2-entry FIFO storing {bcast, src, payload}.
- Counters: tx_count++ per up_tx transfer; rx_count++ per loc_rx transfer; drop_count++ per dropped word. All saturate at 16'hFFFF, never wrap.
- FIFO occupancy per path: 0, 1, 2. Push and pop in same cycle leave occupancy unchanged; order strictly FIFO.

## Timing
- Reset (async assert, any cycle, mid-transfer included): both FIFOs empty, all counters 0, up_tx_valid=0, loc_rx_valid=0, loc_tx_ready=1, up_rx_ready=1; up_tx_data/loc_rx_* = 0. Words in flight are lost.
- loc_tx_ready = (TX occupancy < 2); up_rx_ready = (RX occupancy < 2). Both registered, from occupancy only; not a function of same-cycle pop, so full-with-pop still refuses push.
- Latency: word accepted in cycle N into an empty FIFO presents valid at cycle N+1 output. Throughput 1 word/cycle when downstream ready stays high.
- Outputs valid from FIFO head; data held stable while valid && !ready (AXI-stream rules). valid never retracts without transfer.
- Dropped word still requires a free RX slot (up_rx_ready high); drop does not change occupancy.
- Counter updates visible the cycle after the triggering transfer.

## Test plan
- Reset then loc_tx {dest=8'h00, data=48'h1234} with FPGA_ID=3 -> next cycle up_tx_data=64'h0003_0000_0000_1234, up_tx_valid=1; after transfer tx_count=1.
- up_tx_ready held 0, push 3 local words -> loc_tx_ready drops after 2nd; 3rd stalls; release -> words exit in order, no loss or duplicate.
- up_rx words dest=3, dest=8'hFF, dest=5 (FPGA_ID=3) -> two deliveries (second loc_rx_bcast=1), loc_rx_src = bits[55:48], drop_count=1, rx_count=2.
- loc_rx_ready=0 with continuous up_rx stream -> up_rx_ready low after 2 accepted words; loc_rx_data stable while stalled.
- Force drop_count to 16'hFFFE, send 3 mismatched words -> holds 16'hFFFF.
- Assert reset mid-stream with both FIFOs full -> all valids 0, readies 1, counters 0 immediately (asynchronously).
